// File: rtl/uart_tx_queue_ctrl_if.sv
// Bundles the CPU write path, the status outputs and the transmitter
// handshake of uart_tx_queue_ctrl into one port.
// slave  : the queue controller itself.
// master : its environment, i.e. the CPU write side plus the UART transmitter.
interface uart_tx_queue_ctrl_if #(
  parameter int ADDR_BITS = 4
);
  // CPU write path
  logic                 wr_en;
  logic [7:0]           wr_data;
  logic                 flush;
  logic                 err_clr;

  // Status for the I/O status register
  logic                 full;
  logic                 empty;
  logic [ADDR_BITS:0]   level;
  logic                 busy;
  logic                 err_overflow;
  logic                 err_timeout;

  // Transmitter handshake
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active;
  logic                 tx_done;

  modport slave (
    input  wr_en, wr_data, flush, err_clr, tx_active, tx_done,
    output full, empty, level, busy, err_overflow, err_timeout, tx_dv, tx_byte
  );

  modport master (
    output wr_en, wr_data, flush, err_clr, tx_active, tx_done,
    input  full, empty, level, busy, err_overflow, err_timeout, tx_dv, tx_byte
  );
endinterface

// File: rtl/uart_tx_queue_ctrl.sv
// Buffered UART transmit controller.
// Bytes written by the CPU are queued in a 2**ADDR_BITS deep circular FIFO.
// They are handed to the transmitter one at a time over its DV/active/done
// handshake. A new byte is only presented once tx_done has been seen low,
// so the transmitter never gets stuck in its cleanup phase. If the
// transmitter ignores tx_dv for ISSUE_TIMEOUT cycles, the byte is dropped and
// a sticky timeout flag is raised.
module uart_tx_queue_ctrl #(
  parameter int ADDR_BITS     = 4,
  parameter int ISSUE_TIMEOUT = 64
) (
  input  logic                i_Clock,
  input  logic                reset,
  uart_tx_queue_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int PTR_W = ADDR_BITS + 1;
  localparam int CNT_W = $clog2(ISSUE_TIMEOUT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] LEVEL_FULL   = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ISSUE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state, state_next;

  // FIFO storage and pointers. The extra pointer MSB tells full from empty.
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] level_q;
  logic             full_q;
  logic             empty_q;

  // Transmitter-side registers
  logic [CNT_W-1:0] issue_cnt, issue_cnt_next;
  logic             tx_dv_q, tx_dv_next;
  logic [7:0]       tx_byte_q, tx_byte_next;

  // Sticky error flags
  logic             err_overflow_q;
  logic             err_timeout_q;

  // Per-cycle events
  logic             push;
  logic             pop;
  logic             overflow_evt;
  logic             timeout_evt;

  // A flush wins over a push in the same cycle and is not an overflow.
  assign push         = bus.wr_en && !full_q && !bus.flush;
  assign overflow_evt = bus.wr_en &&  full_q && !bus.flush;

  // Issue sequencing: choose the next state, the registered tx_dv/tx_byte and the timeout count.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and turn it into a latch.
    state_next     = state;
    tx_dv_next     = tx_dv_q;
    tx_byte_next   = tx_byte_q;
    issue_cnt_next = issue_cnt;
    pop            = 1'b0;
    timeout_evt    = 1'b0;

    unique case (state)
      IDLE: begin
        tx_dv_next = 1'b0;
        // Waiting for tx_done low means the transmitter has left cleanup.
        // A byte is not started in a flush cycle, because flush discards
        // everything that has not been handed over yet.
        if (!empty_q && !bus.tx_done && !bus.flush) begin
          tx_byte_next   = mem[rd_ptr[ADDR_BITS-1:0]];
          tx_dv_next     = 1'b1;
          issue_cnt_next = '0;
          pop            = 1'b1;
          state_next     = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.tx_active) begin
          tx_dv_next = 1'b0;
          state_next = BUSY;
        end else if (issue_cnt == TIMEOUT_LAST) begin
          // The transmitter never took the byte, so abandon it.
          tx_dv_next  = 1'b0;
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end else begin
          issue_cnt_next = issue_cnt + CNT_W'(1);
        end
      end

      BUSY: begin
        tx_dv_next = 1'b0;
        if (bus.tx_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        tx_dv_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Pointer update. Flush clears both pointers, and the status outputs follow from the next pointers.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr + PTR_ONE;
    end
    level_next = wr_ptr_next - rd_ptr_next;
  end

  // FIFO storage write port.
  always_ff @(posedge i_Clock) begin
    // NOTE: the storage array has no reset. Only entries between the pointers
    // are ever read, and the pointers themselves are reset.
    if (push) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= bus.wr_data;
    end
  end

  // Registered state, pointers, status and transmitter outputs, with synchronous reset.
  always_ff @(posedge i_Clock) begin
    // NOTE: non-blocking assignments, so every register here sees the
    // pre-edge value of every other one, whatever the statement order.
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      issue_cnt      <= '0;
      tx_dv_q        <= 1'b0;
      tx_byte_q      <= 8'h00;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      level_q   <= level_next;
      full_q    <= (level_next == LEVEL_FULL);
      empty_q   <= (level_next == '0);
      issue_cnt <= issue_cnt_next;
      tx_dv_q   <= tx_dv_next;
      tx_byte_q <= tx_byte_next;

      // A new error event in the same cycle as err_clr keeps the flag set.
      if (overflow_evt)     err_overflow_q <= 1'b1;
      else if (bus.err_clr) err_overflow_q <= 1'b0;

      if (timeout_evt)      err_timeout_q  <= 1'b1;
      else if (bus.err_clr) err_timeout_q  <= 1'b0;
    end
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.level        = level_q;
  assign bus.busy         = !empty_q || (state != IDLE);
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.tx_dv        = tx_dv_q;
  assign bus.tx_byte      = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_queue_ctrl.sv
// Bench for uart_tx_queue_ctrl.
// A behavioural UART transmitter drives the serial line. A line monitor
// decodes each frame and compares it with a queue of expected bytes, which
// the stimulus fills as bytes are accepted.
module tb_uart_tx_queue_ctrl;

  localparam int ADDR_BITS     = 4;
  localparam int DEPTH         = 16;
  localparam int ISSUE_TIMEOUT = 64;

  logic i_Clock = 1'b0;
  logic reset;

  uart_tx_queue_ctrl_if #(.ADDR_BITS(ADDR_BITS)) bus();

  uart_tx_queue_ctrl #(
    .ADDR_BITS    (ADDR_BITS),
    .ISSUE_TIMEOUT(ISSUE_TIMEOUT)
  ) dut (
    .i_Clock(i_Clock),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // Transmitter model knobs and state
  int   clks_per_bit     = 50;
  int   max_accept_delay = 0;
  bit   xmtr_enable      = 1'b1;
  bit   hold_done        = 1'b0;
  logic active_int       = 1'b0;
  logic done_int         = 1'b0;
  logic serial           = 1'b1;
  int   xphase           = 0;
  logic [9:0] xframe;
  int   xcnt, xbit, xwait;

  bit   mon_busy = 1'b0;
  int   dv_rises = 0;

  assign bus.tx_active = active_int;
  assign bus.tx_done   = done_int | hold_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit track);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (track) exp_q.push_back(b);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_full"},         bus.full,         0);
    check({tag, "_empty"},        bus.empty,        1);
    check({tag, "_level"},        bus.level,        0);
    check({tag, "_busy"},         bus.busy,         0);
    check({tag, "_err_overflow"}, bus.err_overflow, 0);
    check({tag, "_err_timeout"},  bus.err_timeout,  0);
    check({tag, "_tx_dv"},        bus.tx_dv,        0);
    check({tag, "_tx_byte"},      bus.tx_byte,      0);
  endtask

  // Wait until the controller, the transmitter and the line are quiet and every expected byte has been seen.
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(bus.busy === 1'b0 && xphase == 0 && !mon_busy &&
             exp_q.size() == 0 && bus.tx_done === 1'b0) && n < budget) begin
      @(negedge i_Clock);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL %s: not idle after %0d cycles, %0d bytes still expected",
               name, budget, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic start_frame();
    active_int = 1'b1;
    serial     = 1'b0;
    xcnt       = 0;
    xbit       = 0;
    xphase     = 2;
  endtask

  // Behavioural transmitter: samples at the negedge and updates just after the next posedge.
  initial begin : xmtr
    logic       dv_s, done_s, rst_s;
    logic [7:0] byte_s;
    forever begin
      @(negedge i_Clock);
      dv_s   = bus.tx_dv;
      done_s = bus.tx_done;
      byte_s = bus.tx_byte;
      rst_s  = reset;
      @(posedge i_Clock);
      #1;
      if (rst_s !== 1'b0) begin
        xphase     = 0;
        active_int = 1'b0;
        done_int   = 1'b0;
        serial     = 1'b1;
      end else begin
        case (xphase)
          0: if (dv_s === 1'b1 && done_s === 1'b0 && xmtr_enable) begin
               xframe = {1'b1, byte_s, 1'b0};
               xwait  = $urandom_range(max_accept_delay, 0);
               if (xwait == 0) start_frame();
               else            xphase = 1;
             end
          1: begin
               xwait--;
               if (xwait == 0) start_frame();
             end
          2: begin
               xcnt++;
               if (xcnt == clks_per_bit) begin
                 xcnt = 0;
                 xbit++;
                 if (xbit == 10) begin
                   active_int = 1'b0;
                   done_int   = 1'b1;
                   serial     = 1'b1;
                   xphase     = 3;
                 end else begin
                   serial = xframe[xbit];
                 end
               end
             end
          default: if (dv_s === 1'b0) begin
               done_int = 1'b0;
               xphase   = 0;
             end
        endcase
      end
    end
  end

  // Every rising edge of tx_dv must follow a cycle in which tx_done was low.
  initial begin : dv_mon
    logic prev_dv   = 1'b0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (bus.tx_dv === 1'b1 && prev_dv === 1'b0) begin
        dv_rises++;
        check("dv_rise_done_low", prev_done, 0);
      end
      prev_dv   = bus.tx_dv;
      prev_done = bus.tx_done;
    end
  end

  // Serial line decoder: pops the next expected byte for each complete frame.
  initial begin : line_mon
    logic [7:0] got;
    bit         ok;
    int         pos, target;
    forever begin
      @(negedge i_Clock);
      if (reset === 1'b0 && serial === 1'b0) begin
        mon_busy = 1'b1;
        ok       = 1'b1;
        pos      = 0;
        got      = '0;
        for (int k = 1; k <= 9; k++) begin
          target = k * clks_per_bit + clks_per_bit / 2;
          while (ok && pos < target) begin
            @(negedge i_Clock);
            pos++;
            if (reset !== 1'b0) ok = 1'b0;
          end
          if (ok && k <= 8) got[k-1] = serial;
        end
        if (ok) begin
          check("stop_bit", serial, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL line_byte: got 0x%02h with nothing expected", got);
          end else begin
            check("line_byte", got, exp_q.pop_front());
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base, hi, guard, n;

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    reset       = 1'b1;
    repeat (3) tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();

    // Three bytes on a CLKS_PER_BIT=50 line
    clks_per_bit = 50;
    base = dv_rises;
    push(8'h41, 1'b1);
    check("t1_level_after_1", bus.level, 1);
    push(8'h42, 1'b1);
    check("t1_level_after_2", bus.level, 1);   // push and pop in one cycle
    push(8'h43, 1'b1);
    check("t1_level_after_3", bus.level, 2);
    wait_idle("t1_idle", 2000);
    check("t1_dv_pulses", dv_rises - base, 3);
    check("t1_busy", bus.busy, 0);
    check("t1_level_end", bus.level, 0);

    // Issue latency from a push into an empty FIFO
    clks_per_bit = 4;
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C; exp_q.push_back(8'h3C);
    tick();                                   // edge N
    bus.wr_en = 1'b0;
    check("lat_empty_N", bus.empty, 0);
    check("lat_dv_N", bus.tx_dv, 0);
    tick();                                   // edge N+1
    check("lat_dv_N1", bus.tx_dv, 1);
    check("lat_byte_N1", bus.tx_byte, 8'h3C);
    tick();                                   // edge N+2: transmitter accepts
    check("lat_dv_N2", bus.tx_dv, 1);
    tick();                                   // edge N+3
    check("lat_dv_N3", bus.tx_dv, 0);
    wait_idle("lat_idle", 200);

    // Flush while a byte is in flight
    clks_per_bit = 8;
    base = dv_rises;
    push(8'h55, 1'b1);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0);
    check("fl_level_before", bus.level, 5);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_level", bus.level, 0);
    check("fl_empty", bus.empty, 1);
    check("fl_busy_inflight", bus.busy, 1);
    wait_idle("fl_idle", 300);
    check("fl_dv_pulses", dv_rises - base, 1);

    // Overflow, then an issue timeout against a silent transmitter
    xmtr_enable = 1'b0;
    hold_done   = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check("ov_full", bus.full, 1);
    check("ov_level", bus.level, 16);
    check("ov_flag_before", bus.err_overflow, 0);
    push(8'hEE, 1'b0);
    check("ov_flag", bus.err_overflow, 1);
    check("ov_level_after", bus.level, 16);
    hold_done = 1'b0;
    guard = 0;
    do begin
      @(negedge i_Clock);
      guard++;
    end while (bus.tx_dv !== 1'b1 && guard < 10);
    if (bus.tx_dv !== 1'b1) begin
      n_checks++;
      $display("FAIL to_dv_start: tx_dv never rose");
    end
    check("to_flag_before", bus.err_timeout, 0);
    hi = 1;
    tick();
    hold_done = 1'b1;                         // keep IDLE from issuing the next byte
    guard = 0;
    forever begin
      @(negedge i_Clock);
      guard++;
      if (bus.tx_dv !== 1'b1 || guard > 200) break;
      hi++;
    end
    check("to_dv_high_cycles", hi, ISSUE_TIMEOUT);
    check("to_flag", bus.err_timeout, 1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("to_flush_level", bus.level, 0);
    check("to_overflow_sticky", bus.err_overflow, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr_overflow", bus.err_overflow, 0);
    check("clr_timeout", bus.err_timeout, 0);
    xmtr_enable = 1'b1;
    hold_done   = 1'b0;
    base = dv_rises;
    repeat (10) tick();
    check("to_no_more_dv", dv_rises - base, 0);
    check("to_busy", bus.busy, 0);

    // Push/pop/flush/err_clr corners
    clks_per_bit = 2;
    hold_done = 1'b1;
    tick();
    for (int i = 0; i < DEPTH - 1; i++) push(8'h80 + 8'(i), 1'b1);
    check("cn_level15", bus.level, 15);
    bus.wr_en = 1'b1; bus.wr_data = 8'h8F; exp_q.push_back(8'h8F);
    hold_done = 1'b0;                         // pop happens on the same edge
    tick();
    bus.wr_en = 1'b0;
    check("cn_push_pop_level", bus.level, 15);
    wait_idle("cn_drain", 800);
    hold_done = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b0);
    check("cn_level3", bus.level, 3);
    bus.wr_en = 1'b1; bus.wr_data = 8'h99; bus.flush = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.flush = 1'b0;
    check("cn_flush_push_level", bus.level, 0);
    check("cn_flush_push_empty", bus.empty, 1);
    check("cn_flush_push_ovf", bus.err_overflow, 0);
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check("cn_full", bus.full, 1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.err_clr = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.err_clr = 1'b0;
    check("cn_clr_vs_ovf", bus.err_overflow, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("cn_clr", bus.err_overflow, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    hold_done = 1'b0;
    tick();

    // Reset during a data bit of a frame
    clks_per_bit = 8;
    push(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) push(8'hD0 + 8'(i), 1'b0);
    guard = 0;
    while (!(xphase == 2 && xbit >= 3) && guard < 200) begin
      @(negedge i_Clock);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL rst_frame_start: frame never reached a data bit");
    end
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("mid");
    reset = 1'b0;
    tick();
    push(8'hA5, 1'b1);
    wait_idle("rst_a5", 300);

    // Randomised bursts of up to one FIFO depth
    clks_per_bit     = 3;
    max_accept_delay = 4;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(16, 1);
      for (int j = 0; j < n; j++) begin
        push(8'($urandom), 1'b1);
        repeat ($urandom_range(3, 0)) tick();
      end
      wait_idle("rnd_burst", 1200);
    end
    check("rnd_no_overflow", bus.err_overflow, 0);
    check("rnd_no_timeout", bus.err_timeout, 0);
    check("rnd_level_end", bus.level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
